// File: rtl/alu_mul_seq_if.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_if
//   Bundle of the signals between the MUL sequencer, the pipeline control that
//   requests a multiply, and the shared EX-stage ALU.
//
//   Request side : start, op_a, op_b
//   ALU side     : alu_result (from ALU), alu_sel/alu_src_a/alu_src_b/alu_ctrl
//                  (to the EX operand mux)
//   Status side  : stall, busy, done, result
//
//   modport slave  : the sequencer's view
//   modport master : the pipeline / ALU environment's view
// ----------------------------------------------------------------------------
interface alu_mul_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_sel;
  logic [XLEN-1:0] alu_src_a;
  logic [XLEN-1:0] alu_src_b;
  logic [3:0]      alu_ctrl;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output alu_sel, alu_src_a, alu_src_b, alu_ctrl,
    output stall, busy, done, result
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  alu_sel, alu_src_a, alu_src_b, alu_ctrl,
    input  stall, busy, done, result
  );
endinterface

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle MUL sequencer that borrows the EX-stage ALU. A shift-add loop
//   performs one ALU add per cycle for exactly XLEN cycles and produces the
//   low XLEN bits of op_a*op_b (RV32M MUL). Sign needs no correction for the
//   low half of the product.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-high
//     bus  : alu_mul_seq_if.slave
//            start/op_a/op_b   request, operands captured on acceptance in IDLE
//            alu_result        combinational sum returned by the shared ALU
//            alu_sel           1 = EX mux feeds alu_src_a/alu_src_b/alu_ctrl
//            alu_src_a/b       accumulator / (multiplicand or 0); 0 when idle
//            alu_ctrl          always ADD (4'b0000)
//            stall             freeze IF/ID/EX
//            busy              high while the loop runs
//            done              one-cycle pulse, result valid
//            result            product, held until the next completion
// ----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
  localparam logic [3:0]       ALU_ADD  = 4'b0000;

  state_t          state_r;
  state_t          next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] result_r;

  logic            alu_sel_s;
  logic [XLEN-1:0] alu_src_a_s;
  logic [XLEN-1:0] alu_src_b_s;
  logic            stall_s;
  logic            busy_s;
  logic            done_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: fixed XLEN-cycle loop, no early exit
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath registers: operand capture, shift-add step, result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= ZERO_X;
      mcand_r  <= ZERO_X;
      mplier_r <= ZERO_X;
      result_r <= ZERO_X;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= ZERO_X;
            mcand_r  <= bus.op_a;
            mplier_r <= bus.op_b;
          end else begin
            cnt_r    <= cnt_r;
          end
        end
        RUN: begin
          acc_r    <= bus.alu_result;
          mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          cnt_r    <= cnt_r + CNT_ONE;
          // Latch the final sum on the edge into DONE so result lines up with done
          if (cnt_r == CNT_LAST) begin
            result_r <= bus.alu_result;
          end else begin
            result_r <= result_r;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode: ALU ownership, stall and status per state
  always_comb begin
    alu_sel_s   = 1'b0;
    alu_src_a_s = ZERO_X;
    alu_src_b_s = ZERO_X;
    stall_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // Stall already in the accept cycle so the MUL instruction holds in EX
        stall_s = bus.start;
      end
      RUN: begin
        alu_sel_s   = 1'b1;
        alu_src_a_s = acc_r;
        if (mplier_r[0]) begin
          alu_src_b_s = mcand_r;
        end else begin
          alu_src_b_s = ZERO_X;
        end
        stall_s = 1'b1;
        busy_s  = 1'b1;
      end
      DONE: begin
        // Still stalled so EX can write back the result this cycle
        stall_s = 1'b1;
        done_s  = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  assign bus.alu_sel   = alu_sel_s;
  assign bus.alu_src_a = alu_src_a_s;
  assign bus.alu_src_b = alu_src_b_s;
  assign bus.alu_ctrl  = ALU_ADD;
  assign bus.stall     = stall_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_mul_seq
//   Directed self-checking bench for alu_mul_seq. A behavioural ALU adds the
//   sequencer's operands while it owns the ALU, and returns a poison value
//   otherwise so any use of alu_result outside RUN corrupts the product.
// ----------------------------------------------------------------------------
module tb_alu_mul_seq;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_seq_if #(.XLEN(XLEN)) bus ();

  assign bus.alu_result = bus.alu_sel ? (bus.alu_src_a + bus.alu_src_b) : 32'hDEAD_BEEF;

  alu_mul_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from IDLE and reports observations; comparisons are
  // made by the calling test. seq_err counts cycles whose ALU-side outputs
  // disagree with the bench's own shift-add model.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int run_cycles, output int done_at,
                         output logic [31:0] res, output int seq_err,
                         output logic stall_pre);
    logic [31:0] acc;
    logic [31:0] mc;
    logic [31:0] mp;
    logic [31:0] exp_b;
    run_cycles = 0;
    done_at    = -1;
    res        = 32'h0;
    seq_err    = 0;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    #1;
    stall_pre  = bus.stall;
    tick();
    bus.start = 1'b0;
    acc = 32'h0;
    mc  = a;
    mp  = b;
    for (int i = 1; i <= 40; i++) begin
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      if (bus.done === 1'b1) begin
        done_at = i;
        res     = bus.result;
        if (bus.busy !== 1'b0 || bus.alu_sel !== 1'b0 || bus.alu_src_a !== 32'h0 ||
            bus.alu_src_b !== 32'h0 || bus.stall !== 1'b1)
          seq_err++;
        bus.start = 1'b0;
        tick();
        break;
      end
      if (bus.busy === 1'b1) begin
        run_cycles++;
        exp_b = mp[0] ? mc : 32'h0;
        if (bus.alu_sel !== 1'b1 || bus.alu_ctrl !== 4'b0000 || bus.alu_src_a !== acc ||
            bus.alu_src_b !== exp_b || bus.stall !== 1'b1)
          seq_err++;
        acc = acc + exp_b;
        mc  = mc << 1;
        mp  = mp >> 1;
        bus.start = ((i % 3) == 0);
      end else begin
        seq_err++;
        bus.start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = 32'h0;
    bus.op_b  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.alu_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b stall=%b done=%b alu_sel=%b, required all 0",
               bus.busy, bus.stall, bus.done, bus.alu_sel);
    end
    n_checks++;
    if (bus.result !== 32'h0 || bus.alu_src_a !== 32'h0 || bus.alu_src_b !== 32'h0 ||
        bus.alu_ctrl !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_data: result=%h src_a=%h src_b=%h ctrl=%h, required 0",
               bus.result, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl);
    end
  endtask

  task automatic test_basic;
    int rc; int da; int se; logic [31:0] r; logic sp;
    run_mul(32'd7, 32'd6, rc, da, r, se, sp);
    n_checks++;
    if (sp !== 1'b1) begin n_fail++; $display("FAIL basic_stall_accept: got %b required 1", sp); end
    n_checks++;
    if (rc !== 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required 32", rc); end
    n_checks++;
    if (da !== 33) begin n_fail++; $display("FAIL basic_done_latency: got %0d required 33", da); end
    n_checks++;
    if (r !== 32'd42) begin n_fail++; $display("FAIL basic_result: got %0d required 42", r); end
    n_checks++;
    if (se !== 0) begin n_fail++; $display("FAIL basic_alu_seq: %0d bad cycles required 0", se); end
    n_checks++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd42) begin
      n_fail++;
      $display("FAIL basic_after: stall=%b done=%b result=%0d required 0 0 42",
               bus.stall, bus.done, bus.result);
    end
  endtask

  task automatic test_overflow;
    int rc; int da; int se; logic [31:0] r; logic sp;
    run_mul(32'hFFFF_FFFF, 32'd5, rc, da, r, se, sp);
    n_checks++;
    if (r !== 32'hFFFF_FFFB || se !== 0) begin
      n_fail++;
      $display("FAIL neg1_x5: got %h (seq_err %0d) required fffffffb (0)", r, se);
    end
    run_mul(32'h8000_0000, 32'd2, rc, da, r, se, sp);
    n_checks++;
    if (r !== 32'h0 || se !== 0) begin
      n_fail++;
      $display("FAIL wrap_x2: got %h (seq_err %0d) required 00000000 (0)", r, se);
    end
  endtask

  task automatic test_zero;
    int rc; int da; int se; logic [31:0] r; logic sp;
    run_mul(32'h0, 32'hFFFF_FFFF, rc, da, r, se, sp);
    n_checks++;
    if (rc !== 32 || da !== 33) begin
      n_fail++;
      $display("FAIL zero_latency: run=%0d done_at=%0d required 32 33", rc, da);
    end
    n_checks++;
    if (r !== 32'h0 || se !== 0) begin
      n_fail++;
      $display("FAIL zero_result: got %h (seq_err %0d) required 0 (0)", r, se);
    end
  endtask

  task automatic test_back_to_back;
    int n_done;
    int first_at;
    int second_at;
    int bad_res;
    n_done    = 0;
    first_at  = -1;
    second_at = -1;
    bad_res   = 0;
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd3;
    bus.start = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) first_at = i;
        if (n_done == 2) second_at = i;
        if (bus.result !== 32'd9) bad_res++;
      end
      // Operands are only valid while idle; garbage elsewhere must be ignored
      if (bus.busy === 1'b0 && bus.done === 1'b0) begin
        bus.op_a = 32'd3;
        bus.op_b = 32'd3;
      end else begin
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (n_done !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses required 2", n_done); end
    n_checks++;
    if (first_at !== 33 || second_at !== 67) begin
      n_fail++;
      $display("FAIL b2b_spacing: pulses at %0d,%0d required 33,67", first_at, second_at);
    end
    n_checks++;
    if (bad_res !== 0) begin n_fail++; $display("FAIL b2b_result: %0d pulses without 9, required 0", bad_res); end
    for (int i = 0; i < 50; i++) begin
      if (bus.busy === 1'b0 && bus.done === 1'b0) break;
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd9) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b done=%b result=%0d required 0 0 9",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid_run;
    int rc; int da; int se; logic [31:0] r; logic sp;
    int saw_done;
    bus.op_a  = 32'd7;
    bus.op_b  = 32'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: busy=%b required 1", bus.busy); end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.alu_sel !== 1'b0 ||
        bus.done !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_abort: busy=%b stall=%b alu_sel=%b done=%b result=%h required 0",
               bus.busy, bus.stall, bus.alu_sel, bus.done, bus.result);
    end
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done++;
    end
    n_checks++;
    if (saw_done !== 0) begin n_fail++; $display("FAIL midrst_quiet: %0d active cycles required 0", saw_done); end
    run_mul(32'd11, 32'd13, rc, da, r, se, sp);
    n_checks++;
    if (r !== 32'd143 || da !== 33 || se !== 0) begin
      n_fail++;
      $display("FAIL midrst_restart: result=%0d done_at=%0d seq_err=%0d required 143 33 0", r, da, se);
    end
  endtask

  task automatic test_random;
    int rc; int da; int se; logic [31:0] r; logic sp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ref_p;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      ref_p = a * b;
      run_mul(a, b, rc, da, r, se, sp);
      n_checks++;
      if (r !== ref_p || rc !== 32 || da !== 33 || se !== 0) begin
        n_fail++;
        $display("FAIL rand_mul: %h*%h got %h required %h (run %0d done_at %0d seq_err %0d)",
                 a, b, r, ref_p, rc, da, se);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
